store_narrow: RTL

//  Sub-word store unit: writes the low byte or halfword of a 32-bit register

---
 rtl/store_narrow.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/store_narrow.sv
// store_narrow: sub-word store unit placed between the datapath store stage
// and a word-addressed data memory port.
//  - Word stores are written straight through.
//  - Byte/half stores read the containing word, merge the new lane(s) into it
//    and write the result back (read-modify-write).
//  - Misaligned or illegal requests are rejected with an err pulse and cause
//    no memory traffic.
// Ports:
//  clk, rst_n                  clock (rising edge), async active-low reset
//  req_valid/req_ready         request handshake; ready only while idle
//  req_addr/req_data/req_size  byte address, store data (LSB-aligned), size
//  mem_addr                    word-aligned memory address
//  mem_rd_en/_data/_valid      read request held until read data strobe
//  mem_wr_en/_data/_ack        write request held until acknowledged
//  done, err                   one-cycle completion / rejection pulses
module store_narrow #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rd_data,
   input  logic              mem_rd_valid,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wr_data,
   input  logic              mem_wr_ack,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [15:0]       data_q,  data_d;   // only the low half is ever merged
   logic [1:0]        size_q,  size_d;
   logic [1:0]        boff_q,  boff_d;   // byte offset inside the word
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q,   err_d;    // RESP reports err instead of done

   logic              req_ill;
   logic [3:0]        be;
   logic [31:0]       merged;

   assign req_ill = (req_size == 2'b11) ||
                    ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

   // Byte lanes replaced by the pending store (little-endian).
   always_comb begin
      be = 4'b0000;
      case (size_q)
         SZ_BYTE: be[boff_q] = 1'b1;
         SZ_HALF: be = boff_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // A byte store always sources data[7:0]; a half store feeds lane k from
   // byte k%2 of data[15:0].
   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [7:0] src;
      assign src = (size_q == SZ_BYTE) ? data_q[7:0] : data_q[8*(k%2) +: 8];
      assign merged[8*k +: 8] = be[k] ? src : mem_rd_data[8*k +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= '0;
         boff_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         size_q  <= size_d;
         boff_q  <= boff_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      size_d  = size_q;
      boff_d  = boff_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d = {req_addr[ADDR_W-1:2], 2'b00};
               boff_d = req_addr[1:0];
               data_d = req_data[15:0];
               size_d = req_size;
               if (req_ill) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (req_size == SZ_WORD) begin
                  err_d   = 1'b0;
                  wdata_d = req_data;
                  state_d = WRITE;
               end else begin
                  err_d   = 1'b0;
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (mem_rd_valid) begin
               wdata_d = merged;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (mem_wr_ack) state_d = RESP;
         end
         default: state_d = IDLE;   // RESP
      endcase
   end

   assign req_ready   = (state_q == IDLE);
   assign mem_rd_en   = (state_q == READ);
   assign mem_wr_en   = (state_q == WRITE);
   assign mem_addr    = addr_q;
   assign mem_wr_data = wdata_q;
   assign done        = (state_q == RESP) && !err_q;
   assign err         = (state_q == RESP) &&  err_q;

endmodule
